// File: rtl/jstk2_spi_responder_pkg.sv
// Shared constants for the JSTK2 SPI responder and its matching master driver:
// frame geometry, JSTK2 command codes and the responder state encoding.
package jstk2_spi_responder_pkg;

  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_TOTAL_DATA_BYTE = 7;
  localparam int DEF_RX_BYTES        = 5;
  localparam int DEF_SYNC_STAGES     = 2;

  localparam logic [7:0] CMD_LED_OFF    = 8'h80;
  localparam logic [7:0] CMD_LED_ON     = 8'h81;
  localparam logic [7:0] CMD_SET_RGB    = 8'h84;
  localparam logic [7:0] CMD_CALIBRATE  = 8'hA0;
  localparam logic [7:0] CMD_GET_STATUS = 8'hF0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/jstk2_spi_responder_spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses taken from the last stage against a delay flop.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {SYNC_STAGES{RST_VAL}};
      dly  <= RST_VAL;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
      dly  <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~dly;
  assign fall  = ~level & dly;

endmodule

// File: rtl/jstk2_spi_responder.sv
// JSTK2 joystick SPI-slave model: captures cmd + 4 params from MOSI and shifts
// a report snapshot (latched at CS fall) out on MISO, all in the i_clk domain.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | CS high, waiting for CS fall; MISO held low
//   ST_ACTIVE | frame in progress; shifting on SCLK edges until CS rise
module jstk2_spi_responder
  import jstk2_spi_responder_pkg::*;
#(
  parameter int TOTAL_DATA_BYTE = DEF_TOTAL_DATA_BYTE,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int RX_BYTES        = DEF_RX_BYTES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic                                  i_clk,
  input  logic                                  i_n_reset,
  input  logic                                  i_cs,
  input  logic                                  i_sclk,
  input  logic                                  i_mosi,
  output logic                                  o_miso,
  input  logic [TOTAL_DATA_BYTE*DATA_WIDTH-1:0] i_tx_data,
  output logic [DATA_WIDTH-1:0]                 o_cmd,
  output logic [DATA_WIDTH-1:0]                 o_param_1,
  output logic [DATA_WIDTH-1:0]                 o_param_2,
  output logic [DATA_WIDTH-1:0]                 o_param_3,
  output logic [DATA_WIDTH-1:0]                 o_param_4,
  output logic [2:0]                            o_rx_count,
  output logic                                  o_cmd_valid,
  output logic                                  o_frame_err,
  output logic                                  o_busy
);

  localparam int TX_W  = TOTAL_DATA_BYTE * DATA_WIDTH;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  state_t state, state_nxt;

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_pins;

  logic frame_end, sclk_rise_act, sclk_fall_act;

  logic [TX_W-1:0]         tx_sr;
  logic [DATA_WIDTH-2:0]   rx_sr;
  logic [BIT_W-1:0]        bit_cnt;
  logic [2:0]              byte_cnt;
  logic [DATA_WIDTH-1:0]   rx_slot [RX_BYTES];

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(i_clk), .rst_n(i_n_reset), .pin(i_cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(i_clk), .rst_n(i_n_reset), .pin(i_sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(i_clk), .rst_n(i_n_reset), .pin(i_mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_pins = sclk_lvl ^ mosi_rise ^ mosi_fall;

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // CS rise takes priority over any SCLK edge detected in the same cycle.
  always_comb begin
    state_nxt     = state;
    frame_end     = 1'b0;
    sclk_rise_act = 1'b0;
    sclk_fall_act = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_nxt = ST_IDLE;
          frame_end = 1'b1;
        end else if (!cs_lvl) begin
          sclk_rise_act = sclk_rise;
          sclk_fall_act = sclk_fall;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy = (state == ST_ACTIVE);

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      o_miso      <= 1'b0;
      o_cmd       <= '0;
      o_param_1   <= '0;
      o_param_2   <= '0;
      o_param_3   <= '0;
      o_param_4   <= '0;
      o_rx_count  <= '0;
      o_cmd_valid <= 1'b0;
      o_frame_err <= 1'b0;
      for (int i = 0; i < RX_BYTES; i++) rx_slot[i] <= '0;
    end else begin
      o_cmd_valid <= 1'b0;
      o_frame_err <= 1'b0;
      if (state == ST_IDLE && cs_fall) begin
        tx_sr    <= i_tx_data;
        o_miso   <= i_tx_data[TX_W-1];
        bit_cnt  <= '0;
        byte_cnt <= '0;
        for (int i = 0; i < RX_BYTES; i++) rx_slot[i] <= '0;
      end else if (frame_end) begin
        o_cmd       <= rx_slot[0];
        o_param_1   <= rx_slot[1];
        o_param_2   <= rx_slot[2];
        o_param_3   <= rx_slot[3];
        o_param_4   <= rx_slot[4];
        o_rx_count  <= (byte_cnt > 3'(RX_BYTES)) ? 3'(RX_BYTES) : byte_cnt;
        o_cmd_valid <= (byte_cnt != 3'd0);
        o_frame_err <= (bit_cnt != '0);
        o_miso      <= 1'b0;
      end else begin
        if (sclk_rise_act) begin
          rx_sr <= {rx_sr[DATA_WIDTH-3:0], mosi_lvl};
          if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
            bit_cnt <= '0;
            if (byte_cnt < 3'(RX_BYTES)) rx_slot[byte_cnt] <= {rx_sr, mosi_lvl};
            if (byte_cnt != 3'd7) byte_cnt <= byte_cnt + 3'd1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        // Zero fill means MISO falls to 0 once the report is exhausted.
        if (sclk_fall_act) begin
          tx_sr  <= tx_sr << 1;
          o_miso <= tx_sr[TX_W-2];
        end
      end
    end
  end

endmodule
